hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised hazard unit for the 5-stage pipeline. Generates forwarding selects,
//  load-use and RAW stalls, and branch/jump flushes. Adds a multi-cycle execute
//  sequencer (MUL/DIV held in E for MC_LAT cycles) and a saturating stall-cycle counter.
//  Sits beside the pipeline controller and drives the stall/flush pins of every stage register.
// PARAMETERS
//  REG_AW  5   register-index width
//  MC_LAT  4   cycles a multi-cycle op occupies E; legal range 2..2**8
//  FWD_EN  1   1: forwarding from M/W; 0: no forwarding, RAW resolved by stalling in D
//  CNT_W   32  stall-cycle counter width
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low
//  rs1D,rs2D    in   REG_AW  source registers in D
//  rs1E,rs2E    in   REG_AW  source registers in E
//  rdE,rdM,rdW  in   REG_AW  destination registers in E/M/W
//  reg_writeE   in   1       E instruction writes rd
//  reg_writeM   in   1       M instruction writes rd
//  reg_writeW   in   1       W instruction writes rd
//  loadE        in   1       E instruction is a load (result from memory)
//  pc_srcE      in   1       taken branch/jump resolved in E
//  mc_startE    in   1       E holds a multi-cycle op
//  cnt_clr      in   1       synchronous clear of stall_cnt
//  forward_aE   out  2       00 regfile, 10 from M, 01 from W
//  forward_bE   out  2       as forward_aE, for rs2E
//  stallF,stallD,stallE out 1 hold stage register
//  flushD,flushE,flushM out 1 bubble next stage register
//  mc_busy      out  1       sequencer in BUSY
//  mc_doneE     out  1       1-cycle pulse: multi-cycle op leaves E this cycle
//  stall_cnt    out  CNT_W   cycles with stallF=1, saturating
// BEHAVIOUR
//  - Reset: state IDLE, mc counter 0, stall_cnt 0; all outputs derive combinationally.
//  - match(x,y) = (x!=0)&&(x==y); x0 never forwards or stalls.
//  - Forward (FWD_EN=1): fwd_a = reg_writeM&&match(rdM,rs1E) ? 10 :
//    reg_writeW&&match(rdW,rs1E) ? 01 : 00; M has priority. Same for b. FWD_EN=0: 00.
//  - lw_stall = loadE&&reg_writeE&&(match(rdE,rs1D)||match(rdE,rs2D)).
//  - raw_stall (FWD_EN=0 only) = any D source matches rdE (reg_writeE) or rdM (reg_writeM);
//    regfile is write-through, so W needs no stall.
//  - Sequencer FSM, 8-bit down-counter mc_cnt:
//    IDLE: mc_startE -> BUSY, mc_cnt<=MC_LAT-2; mc_stall=1 this cycle.
//    BUSY: mc_cnt!=0 -> mc_cnt--, mc_stall=1; mc_cnt==0 -> mc_doneE=1, mc_stall=0, -> IDLE.
//    mc_startE ignored in BUSY. Op occupies E exactly MC_LAT cycles (MC_LAT-1 stalls).
//  - Priority (high->low): mc_stall > pc_srcE > lw_stall/raw_stall.
//    mc_stall: stallF=stallD=stallE=1, flushM=1, flushD=flushE=0.
//    pc_srcE: flushD=flushE=1, stalls 0 (D instruction is squashed, its hazard is void).
//    lw/raw: stallF=stallD=1, flushE=1.
//  - stall_cnt: cnt_clr -> 0 (wins); else +1 when stallF, holds at 2**CNT_W-1.
//  - Reset mid-operation: BUSY aborts to IDLE asynchronously, all stalls drop.
// TESTING
//  1 rdM=5,reg_writeM=1,rdW=5,reg_writeW=1,rs1E=5 -> forward_aE=10; rdM=0 same case -> 01.
//  2 loadE=1,rdE=7,rs2D=7 -> stallF=stallD=flushE=1 one cycle; rdE=0 -> no stall.
//  3 MC_LAT=4, mc_startE pulse -> stallF/D/E=1 for 3 cycles, flushM=1 same cycles,
//    mc_doneE=1 in 4th, stall_cnt=3.
//  4 pc_srcE=1 with lw_stall=1 -> flushD=flushE=1, stallF=0.
//  5 FWD_EN=0, reg_writeM=1,rdM=3,rs1D=3 -> stallF=1, forward_aE=00.
//  6 reset low at BUSY cycle 2 -> mc_busy=0, stalls 0, stall_cnt=0 immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: forwarding, stalls, flushes, multi-cycle sequencer, stall counter
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              reg_writeE,
  input  logic              reg_writeM,
  input  logic              reg_writeW,
  input  logic              loadE,
  input  logic              pc_srcE,
  input  logic              mc_startE,
  input  logic              cnt_clr,
  output logic [1:0]        forward_aE,
  output logic [1:0]        forward_bE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              mc_busy,
  output logic              mc_doneE,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  // First BUSY cycle already counts as one occupied cycle beyond the IDLE start cycle
  localparam logic [7:0]       MC_INIT = 8'(MC_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic [7:0] mc_cnt;
  logic       mc_stall;
  logic       lw_stall;
  logic       raw_stall;

  // Register x0 is hardwired to zero, so it never creates a dependency
  function automatic logic match(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] y);
    return (x != '0) && (x == y);
  endfunction

  // Forwarding selects for the E-stage operands; the younger M result wins over W
  always_comb begin
    forward_aE = 2'b00;
    forward_bE = 2'b00;
    if (FWD_EN != 0) begin
      if (reg_writeM && match(rdM, rs1E))      forward_aE = 2'b10;
      else if (reg_writeW && match(rdW, rs1E)) forward_aE = 2'b01;
      if (reg_writeM && match(rdM, rs2E))      forward_bE = 2'b10;
      else if (reg_writeW && match(rdW, rs2E)) forward_bE = 2'b01;
    end
  end

  // Data hazards detected in D: load-use always, plain RAW only without forwarding
  always_comb begin
    lw_stall  = loadE && reg_writeE && (match(rdE, rs1D) || match(rdE, rs2D));
    raw_stall = 1'b0;
    if (FWD_EN == 0) begin
      raw_stall = (reg_writeE && (match(rdE, rs1D) || match(rdE, rs2D))) ||
                  (reg_writeM && (match(rdM, rs1D) || match(rdM, rs2D)));
    end
  end

  // Multi-cycle sequencer: holds the op in E for MC_LAT cycles; new starts ignored while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mc_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mc_startE) begin
            state  <= BUSY;
            mc_cnt <= MC_INIT;
          end
        end
        BUSY: begin
          if (mc_cnt != 8'd0) mc_cnt <= mc_cnt - 8'd1;
          else                state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sequencer status decoded from state so the stall reaches the stage registers in the start cycle
  always_comb begin
    mc_busy  = (state == BUSY);
    mc_doneE = (state == BUSY) && (mc_cnt == 8'd0);
    mc_stall = (state == IDLE) ? mc_startE : (mc_cnt != 8'd0);
  end

  // Stage control with priority: multi-cycle hold, then redirect, then data hazards
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (mc_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (pc_srcE) begin
      // The D instruction is squashed, so any hazard it raised is void
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (lw_stall || raw_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  // Saturating count of fetch-stall cycles; clear beats increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stallF && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       reg_writeE, reg_writeM, reg_writeW, loadE, pc_srcE, mc_startE, cnt_clr;

  // instance a: defaults (forwarding, MC_LAT=4, 32-bit counter)
  logic [1:0]  a_fa, a_fb;
  logic        a_sF, a_sD, a_sE, a_fD, a_fE, a_fM, a_busy, a_done;
  logic [31:0] a_cnt;
  // instance b: no forwarding
  logic [1:0]  b_fa, b_fb;
  logic        b_sF, b_sD, b_sE, b_fD, b_fE, b_fM, b_busy, b_done;
  logic [31:0] b_cnt;
  // instance c: shortest latency, 2-bit counter
  logic [1:0]  c_fa, c_fb;
  logic        c_sF, c_sD, c_sE, c_fD, c_fE, c_fM, c_busy, c_done;
  logic [1:0]  c_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_a (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .reg_writeE(reg_writeE), .reg_writeM(reg_writeM),
    .reg_writeW(reg_writeW), .loadE(loadE), .pc_srcE(pc_srcE), .mc_startE(mc_startE),
    .cnt_clr(cnt_clr), .forward_aE(a_fa), .forward_bE(a_fb), .stallF(a_sF), .stallD(a_sD),
    .stallE(a_sE), .flushD(a_fD), .flushE(a_fE), .flushM(a_fM), .mc_busy(a_busy),
    .mc_doneE(a_done), .stall_cnt(a_cnt));

  hazard_ctrl #(.FWD_EN(0)) u_b (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .reg_writeE(reg_writeE), .reg_writeM(reg_writeM),
    .reg_writeW(reg_writeW), .loadE(loadE), .pc_srcE(pc_srcE), .mc_startE(mc_startE),
    .cnt_clr(cnt_clr), .forward_aE(b_fa), .forward_bE(b_fb), .stallF(b_sF), .stallD(b_sD),
    .stallE(b_sE), .flushD(b_fD), .flushE(b_fE), .flushM(b_fM), .mc_busy(b_busy),
    .mc_doneE(b_done), .stall_cnt(b_cnt));

  hazard_ctrl #(.MC_LAT(2), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .reg_writeE(reg_writeE), .reg_writeM(reg_writeM),
    .reg_writeW(reg_writeW), .loadE(loadE), .pc_srcE(pc_srcE), .mc_startE(mc_startE),
    .cnt_clr(cnt_clr), .forward_aE(c_fa), .forward_bE(c_fb), .stallF(c_sF), .stallD(c_sD),
    .stallE(c_sE), .flushD(c_fD), .flushE(c_fE), .flushM(c_fM), .mc_busy(c_busy),
    .mc_doneE(c_done), .stall_cnt(c_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    reg_writeE = 0; reg_writeM = 0; reg_writeW = 0; loadE = 0; pc_srcE = 0;
    mc_startE = 0; cnt_clr = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #2;
    chk("rst_busy", {31'd0, a_busy}, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_stallF", {31'd0, a_sF}, 0);
    step();
    reset = 1'b1;
    step();

    // forwarding: M beats W, W used when M is x0, x0 never forwards
    rdM = 5; reg_writeM = 1; rdW = 5; reg_writeW = 1; rs1E = 5;
    #1;
    chk("fwd_a_M", {30'd0, a_fa}, 2'b10);
    chk("fwd_b_none", {30'd0, a_fb}, 2'b00);
    chk("nofwd_a", {30'd0, b_fa}, 2'b00);
    rdM = 0; rs2E = 5;
    #1;
    chk("fwd_a_W", {30'd0, a_fa}, 2'b01);
    chk("fwd_b_W", {30'd0, a_fb}, 2'b01);
    rdW = 0; rs1E = 0; rs2E = 0;
    #1;
    chk("fwd_x0", {30'd0, a_fa}, 2'b00);
    idle_inputs();
    step();

    // load-use stall
    loadE = 1; reg_writeE = 1; rdE = 7; rs2D = 7;
    #1;
    chk("lw_stall", {26'd0, a_sF, a_sD, a_sE, a_fD, a_fE, a_fM}, 6'b110010);
    step();
    chk("lw_cnt", a_cnt, 1);
    rdE = 0;
    #1;
    chk("lw_x0", {31'd0, a_sF}, 0);
    // clear wins over a concurrent stall
    rdE = 7; cnt_clr = 1;
    step();
    chk("clr_wins", a_cnt, 0);
    idle_inputs();
    step();

    // multi-cycle op, MC_LAT=4 (instance a) and MC_LAT=2 (instance c)
    mc_startE = 1;
    #1;
    chk("mc_c0", {26'd0, a_sF, a_sD, a_sE, a_fD, a_fE, a_fM}, 6'b111001);
    chk("mc_c0_busy", {31'd0, a_busy}, 0);
    step();
    mc_startE = 0;
    #1;
    chk("mc_c1", {29'd0, a_busy, a_sE, a_fM}, 3'b111);
    chk("mc2_done", {30'd0, c_done, c_sF}, 2'b10);
    step();
    pc_srcE = 1;
    #1;
    chk("mc_over_br", {28'd0, a_sF, a_fD, a_fE, a_fM}, 4'b1001);
    chk("mc2_idle_br", {29'd0, c_busy, c_fD, c_fE}, 3'b011);
    pc_srcE = 0;
    step();
    chk("mc_done", {28'd0, a_done, a_busy, a_sF, a_fM}, 4'b1100);
    step();
    chk("mc_after", {30'd0, a_done, a_busy}, 2'b00);
    chk("mc_cnt", a_cnt, 3);
    chk("mc2_cnt", {30'd0, c_cnt}, 1);

    // branch outranks load-use
    loadE = 1; reg_writeE = 1; rdE = 7; rs1D = 7; pc_srcE = 1;
    #1;
    chk("br_over_lw", {28'd0, a_sF, a_sD, a_fD, a_fE}, 4'b0011);
    idle_inputs();
    step();

    // RAW without forwarding stalls in D; with forwarding it does not
    reg_writeM = 1; rdM = 3; rs1D = 3; rs1E = 3;
    #1;
    chk("raw_stall", {29'd0, b_sF, b_sD, b_fE}, 3'b111);
    chk("raw_fwd_a", {30'd0, b_fa}, 2'b00);
    chk("raw_fwd_on", {29'd0, a_sF, a_fa}, 3'b010);
    idle_inputs();
    cnt_clr = 1;
    step();
    cnt_clr = 0;

    // saturation of the narrow counter
    loadE = 1; reg_writeE = 1; rdE = 7; rs2D = 7;
    for (int i = 0; i < 5; i++) step();
    chk("sat_c", {30'd0, c_cnt}, 3);
    chk("sat_a", a_cnt, 5);
    idle_inputs();
    step();

    // asynchronous reset in the middle of a multi-cycle op
    mc_startE = 1;
    step();
    mc_startE = 0;
    step();
    chk("pre_rst_busy", {31'd0, a_busy}, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid", {28'd0, a_busy, a_sF, a_sE, a_fM}, 4'b0000);
    chk("rst_mid_cnt", a_cnt, 0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst", {30'd0, a_busy, a_sF}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
